// File: rtl/arp_cache_pkg.sv
// Shared types and helpers for the N-way IPv4 -> MAC ARP cache.
package arp_cache_pkg;

  localparam int          ENTRY_AGE_W = 8;
  localparam logic [31:0] IP_ZERO     = 32'h0000_0000;

  typedef struct packed {
    logic                   valid;
    logic [31:0]            ip;
    logic [47:0]            mac;
    logic [ENTRY_AGE_W-1:0] age;
  } arp_entry_t;

  typedef enum logic [2:0] {
    LK_IDLE   = 3'd0,
    LK_SEARCH = 3'd1,
    LK_REQ    = 3'd2,
    LK_SENT   = 3'd3,
    LK_WAIT   = 3'd4,
    LK_DONE   = 3'd5
  } lookup_state_e;

  function automatic logic [ENTRY_AGE_W-1:0] age_bump(input logic [ENTRY_AGE_W-1:0] age,
                                                      input logic [ENTRY_AGE_W-1:0] age_max);
    return (age >= age_max) ? age : age + 1'b1;
  endfunction

endpackage

// File: rtl/arp_entry_table.sv
// Entry storage for the ARP cache: learn/replace, aging, flush and a parallel compare port.
module arp_entry_table
  import arp_cache_pkg::*;
#(
  parameter int ENTRIES   = 4,
  parameter int IDX_W     = $clog2(ENTRIES),
  parameter int AGE_W     = 8,
  parameter int AGE_LIMIT = 200
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic             learn_valid,
  input  logic [31:0]      learn_ip,
  input  logic [47:0]      learn_mac,
  input  logic             flush,
  input  logic             tick,
  input  logic [31:0]      cmp_ip,
  output logic             cmp_hit,
  output logic [47:0]      cmp_mac,
  output logic [IDX_W:0]   entry_count
);

  localparam logic [ENTRY_AGE_W-1:0] AGE_MAX = ENTRY_AGE_W'((1 << AGE_W) - 1);
  localparam logic [ENTRY_AGE_W-1:0] AGE_LIM = ENTRY_AGE_W'(AGE_LIMIT);

  arp_entry_t             tbl_q [ENTRIES];
  logic [IDX_W-1:0]       cmp_idx;
  logic                   lrn_hit, free_hit, wr_en;
  logic [IDX_W-1:0]       lrn_idx, free_idx, old_idx, wr_idx;
  logic [ENTRY_AGE_W-1:0] old_age;
  logic [IDX_W:0]         cnt_next;

  // Descending scans leave the lowest matching index selected.
  always_comb begin
    cmp_hit  = 1'b0;
    cmp_idx  = '0;
    lrn_hit  = 1'b0;
    lrn_idx  = '0;
    free_hit = 1'b0;
    free_idx = '0;
    cnt_next = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (tbl_q[i].valid && tbl_q[i].ip == cmp_ip) begin
        cmp_hit = 1'b1;
        cmp_idx = IDX_W'(i);
      end
      if (tbl_q[i].valid && tbl_q[i].ip == learn_ip) begin
        lrn_hit = 1'b1;
        lrn_idx = IDX_W'(i);
      end
      if (!tbl_q[i].valid) begin
        free_hit = 1'b1;
        free_idx = IDX_W'(i);
      end
      cnt_next = cnt_next + {{IDX_W{1'b0}}, tbl_q[i].valid};
    end
  end

  // Strict compare keeps the lowest index on equal ages.
  always_comb begin
    old_idx = '0;
    old_age = tbl_q[0].age;
    for (int i = 1; i < ENTRIES; i++) begin
      if (tbl_q[i].age > old_age) begin
        old_age = tbl_q[i].age;
        old_idx = IDX_W'(i);
      end
    end
  end

  assign cmp_mac = cmp_hit ? tbl_q[cmp_idx].mac : 48'h0;
  assign wr_en   = learn_valid && (learn_ip != IP_ZERO);
  assign wr_idx  = lrn_hit ? lrn_idx : (free_hit ? free_idx : old_idx);

  always_ff @(posedge aclk) begin
    if (areset) begin
      for (int i = 0; i < ENTRIES; i++) tbl_q[i] <= '0;
      entry_count <= '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (flush) begin
          tbl_q[i].valid <= 1'b0;
          tbl_q[i].age   <= '0;
        end else if (wr_en && wr_idx == IDX_W'(i)) begin
          tbl_q[i] <= '{valid: 1'b1, ip: learn_ip, mac: learn_mac, age: '0};
        end else if (tick && tbl_q[i].valid) begin
          tbl_q[i].age <= age_bump(tbl_q[i].age, AGE_MAX);
          if (age_bump(tbl_q[i].age, AGE_MAX) >= AGE_LIM) tbl_q[i].valid <= 1'b0;
        end
      end
      entry_count <= cnt_next;
    end
  end

endmodule

// File: rtl/arp_cache_nway.sv
// N-entry ARP cache: lookup FSM, age prescaler and ARP request retry/timeout control.
//
//   state  | meaning
//   IDLE   | ready for a lookup request
//   SEARCH | compare latched IP against the table
//   REQ    | pulse arp_rq_start, count the attempt
//   SENT   | wait for the request frame to leave
//   WAIT   | wait for a matching reply or the reply timeout
//   DONE   | one-cycle result strobe
module arp_cache_nway
  import arp_cache_pkg::*;
#(
  parameter int  ENTRIES     = 4,
  parameter int  AGE_W       = 8,
  parameter int  AGE_LIMIT   = 200,
  parameter int  TICK_DIV    = 125000000,
  parameter int  REQ_TIMEOUT = 1250000,
  parameter int  REQ_RETRIES = 3,
  localparam int IDX_W       = $clog2(ENTRIES)
) (
  input  logic           aclk,
  input  logic           areset,
  input  logic           learn_valid,
  input  logic [31:0]    learn_ip,
  input  logic [47:0]    learn_mac,
  input  logic           flush,
  input  logic           lookup_valid,
  input  logic [31:0]    lookup_ip,
  output logic           lookup_ready,
  output logic           lookup_done,
  output logic           lookup_hit,
  output logic [47:0]    lookup_mac,
  output logic           arp_rq_start,
  output logic [31:0]    arp_rq_ip,
  input  logic           arp_rq_done,
  output logic [IDX_W:0] entry_count
);

  localparam int PRE_W = $clog2(TICK_DIV + 1);
  localparam int TMR_W = $clog2(REQ_TIMEOUT) + 1;
  localparam int RTY_W = $clog2(REQ_RETRIES + 1);

  localparam logic [PRE_W-1:0] PRE_LOAD = PRE_W'(TICK_DIV - 1);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(REQ_TIMEOUT - 1);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(REQ_RETRIES);

  localparam logic [2:0] IDLE   = LK_IDLE;
  localparam logic [2:0] SEARCH = LK_SEARCH;
  localparam logic [2:0] REQ    = LK_REQ;
  localparam logic [2:0] SENT   = LK_SENT;
  localparam logic [2:0] WAIT   = LK_WAIT;
  localparam logic [2:0] DONE   = LK_DONE;

  logic [2:0]       state_q;
  logic [31:0]      ip_q;
  logic [RTY_W-1:0] rty_q;
  logic [TMR_W-1:0] tmr_q;
  logic [PRE_W-1:0] pre_q;
  logic             hit_q;
  logic [47:0]      mac_q;
  logic             tick;
  logic             srch_hit;
  logic [47:0]      srch_mac;

  assign tick = (pre_q == '0);

  arp_entry_table #(
    .ENTRIES  (ENTRIES),
    .IDX_W    (IDX_W),
    .AGE_W    (AGE_W),
    .AGE_LIMIT(AGE_LIMIT)
  ) u_table (
    .aclk       (aclk),
    .areset     (areset),
    .learn_valid(learn_valid),
    .learn_ip   (learn_ip),
    .learn_mac  (learn_mac),
    .flush      (flush),
    .tick       (tick),
    .cmp_ip     (ip_q),
    .cmp_hit    (srch_hit),
    .cmp_mac    (srch_mac),
    .entry_count(entry_count)
  );

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= IDLE;
      ip_q    <= '0;
      rty_q   <= '0;
      tmr_q   <= '0;
      pre_q   <= PRE_LOAD;
      hit_q   <= 1'b0;
      mac_q   <= '0;
    end else begin
      pre_q <= tick ? PRE_LOAD : pre_q - 1'b1;
      case (state_q)
        IDLE: if (lookup_valid) begin
          ip_q    <= lookup_ip;
          rty_q   <= '0;
          state_q <= SEARCH;
        end
        SEARCH: if (srch_hit) begin
          hit_q   <= 1'b1;
          mac_q   <= srch_mac;
          state_q <= DONE;
        end else begin
          state_q <= REQ;
        end
        REQ: begin
          rty_q   <= rty_q + 1'b1;
          state_q <= SENT;
        end
        SENT: if (arp_rq_done) begin
          tmr_q   <= TMR_LOAD;
          state_q <= WAIT;
        end
        // A matching reply wins over an expiring timer in the same cycle.
        WAIT: if (learn_valid && learn_ip == ip_q) begin
          hit_q   <= 1'b1;
          mac_q   <= learn_mac;
          state_q <= DONE;
        end else if (tmr_q == '0) begin
          if (rty_q < RTY_MAX) begin
            state_q <= REQ;
          end else begin
            hit_q   <= 1'b0;
            mac_q   <= '0;
            state_q <= DONE;
          end
        end else begin
          tmr_q <= tmr_q - 1'b1;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign lookup_ready = (state_q == IDLE) && !areset;
  assign lookup_done  = (state_q == DONE);
  assign lookup_hit   = hit_q;
  assign lookup_mac   = mac_q;
  assign arp_rq_start = (state_q == REQ);
  assign arp_rq_ip    = ip_q;

endmodule

// File: doc/arp_cache_nway.md
Name: arp_cache_nway

Overview:
- Parametrised successor to the single-entry ARP cache: an N-entry IPv4→MAC table with learning, age-out, replacement and miss-driven ARP request generation with retry/timeout.
- Sits between eth_rx (learn path: validated ARP sender IP/MAC) and eth_tx / the request/response arbiter (ARP request start/done).
- Serves a lookup handshake used by the UDP TX path to resolve a destination IP before framing.

Parameters:
- ENTRIES, 4, number of table entries (≥2); index width IDX_W = $clog2(ENTRIES).
- AGE_W, 8, age counter width per entry.
- AGE_LIMIT, 200, age value (in ticks) at which an entry is invalidated; ≤ 2^AGE_W−1.
- TICK_DIV, 125000000, aclk cycles per age tick (1 s at 125 MHz).
- REQ_TIMEOUT, 1250000, cycles to wait for a reply after arp_rq_done.
- REQ_RETRIES, 3, ARP requests sent per miss before reporting failure.

Ports:
- aclk  in  1  clock; all logic on rising edge.
- areset  in  1  synchronous, active-high reset.
- learn_valid  in  1  one-cycle strobe: validated ARP packet (CRC good) received.
- learn_ip  in  32  sender protocol address.
- learn_mac  in  48  sender hardware address.
- flush  in  1  one-cycle strobe: invalidate all entries.
- lookup_valid  in  1  lookup request.
- lookup_ip  in  32  IP to resolve; held stable while lookup_valid && !lookup_ready.
- lookup_ready  out  1  high in IDLE only.
- lookup_done  out  1  one-cycle result strobe.
- lookup_hit  out  1  qualified by lookup_done: 1 = resolved.
- lookup_mac  out  48  qualified by lookup_done && lookup_hit.
- arp_rq_start  out  1  one-cycle pulse: transmit ARP request.
- arp_rq_ip  out  32  target IP for the request; stable from pulse until arp_rq_done.
- arp_rq_done  in  1  one-cycle strobe from TX: request frame sent.
- entry_count  out  IDX_W+1  number of valid entries.

Behaviour:
- Reset: all entries invalid, ages 0; lookup_ready=0 in the reset cycle, then 1; all other outputs 0; prescaler and FSM cleared. Reset mid-lookup abandons it; no lookup_done is issued.
- Learn, one cycle, visible to a compare starting the next cycle:
  - learn_ip==0 (ARP probe) is ignored.
  - If learn_ip matches a valid entry: overwrite its MAC, age←0.
  - Else write the lowest-index invalid entry.
  - Else evict the valid entry with the largest age; ties go to the lowest index.
- Aging: prescaler counts to TICK_DIV−1, then emits a one-cycle tick. On a tick, each valid entry's age increments (saturating at 2^AGE_W−1). An entry whose incremented age ≥ AGE_LIMIT becomes invalid that cycle.
- Simultaneous events, in priority order: flush > learn > tick for the same entry. A refreshed entry gets age 0, not 1. flush also overrides a same-cycle learn.
- FSM states: IDLE, SEARCH, REQ, SENT, WAIT, DONE.
  - IDLE: lookup_ready=1. On lookup_valid, latch lookup_ip into ip_q, retry counter←0 → SEARCH.
  - SEARCH: one-cycle parallel compare of ip_q against valid entries. Hit → DONE(hit=1, mac). Miss → REQ.
  - REQ: pulse arp_rq_start with arp_rq_ip=ip_q, retry counter+1 → SENT.
  - SENT: wait arp_rq_done; timer←0 → WAIT.
  - WAIT:
    - learn_valid with learn_ip==ip_q → DONE(hit=1, learn_mac); the table is also written.
    - Else timer reaching REQ_TIMEOUT−1 → REQ if retry counter<REQ_RETRIES, otherwise DONE(hit=0, mac=0).
    - flush while in WAIT has no effect on the FSM.
  - DONE: lookup_done=1 for one cycle → IDLE.
- Hit latency: lookup_valid accepted in cycle n → lookup_done in n+2.
- A learn in the same cycle as SEARCH is not seen by that compare. A miss then proceeds to REQ; the WAIT-state match covers it only if another reply arrives.
- entry_count is registered and reflects table state one cycle after each change.
- Width rules: ages and the prescaler saturate or wrap only as stated; the timer width is $clog2(REQ_TIMEOUT)+1.

Decomposition:
- Package arp_cache_pkg:
  - arp_entry_t struct {valid, ip[31:0], mac[47:0], age[AGE_W-1:0]} (AGE_W passed as a type parameter or fixed in the package).
  - lookup_state_e enum.
  - IP_ZERO constant.
- Sub-module arp_entry_table: owns the storage array, learn/replace/aging/flush logic and the combinational compare port (ip in → hit, idx, mac). The top level holds the FSM, prescaler, request timer and retry counter.

Test Plan:
- Learn 192.168.1.10 / 00:11:22:33:44:55; lookup 192.168.1.10 → lookup_done at n+2, hit=1, mac=00:11:22:33:44:55, no arp_rq_start.
- Lookup unknown 192.168.1.20; return arp_rq_done after 5 cycles, then learn 192.168.1.20 / AA:BB:CC:DD:EE:01 in WAIT → one arp_rq_start, arp_rq_ip=C0A80114, done hit=1 with that MAC; entry_count=1.
- REQ_RETRIES=3, REQ_TIMEOUT=16, no reply → exactly 3 arp_rq_start pulses ≥16 cycles apart, then done hit=0, mac=0.
- ENTRIES=4, fill 4 IPs, age the table with TICK_DIV=4, refresh entry 2, learn a 5th IP → the oldest-aged entry is evicted; ties resolve to the lowest index; entry 2 is retained; entry_count stays 4.
- AGE_LIMIT=3, TICK_DIV=4 → entry invalid after 3 ticks (12 cycles); learn the same entry exactly on the 3rd tick → entry stays valid with age 0. Learn 0.0.0.0 → ignored.
- Assert areset during WAIT → no lookup_done; next cycle outputs 0, entry_count=0. Assert flush together with learn → table empty.
